// File: rtl/decode_pkg.sv
// Shared constants and the ID/EX payload record for the decode stage.
// Default widths here are the ones the top level and the bench build against.
package decode_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_RADDR_W    = 3;
    localparam int DEF_SIG_W      = 23;
    localparam int DEF_INPORT_BIT = 18;
    localparam int DEF_MEMRD_BIT  = 12;

    typedef struct packed {
        logic                     valid;
        logic [DEF_SIG_W-1:0]     sig;
        logic [DEF_DATA_W-1:0]    opa;
        logic [DEF_DATA_W-1:0]    opb;
        logic [DEF_RADDR_W-1:0]   rsrc1;
        logic [DEF_RADDR_W-1:0]   rsrc2;
        logic [DEF_RADDR_W-1:0]   rdst;
    } idex_payload_t;

endpackage

// File: rtl/reg_file_param.sv
// NUM_REGS x DATA_W register file: two combinational read ports, one write port,
// optional same-cycle write-through so a WB write is visible to an ID read.
module reg_file_param #(
    parameter int DATA_W    = 16,
    parameter int RADDR_W   = 3,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we_i,
    input  logic [RADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]  wdata_i,
    input  logic [RADDR_W-1:0] raddr1_i,
    input  logic [RADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0]  rdata1_o,
    output logic [DATA_W-1:0]  rdata2_o
);

    localparam int NUM_REGS = 2 ** RADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Storage: cleared on reset, written by WB; register 0 is an ordinary register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Read ports, with optional write-through of the in-flight WB value.
    always_comb begin
        rdata1_o = regs_q[raddr1_i];
        rdata2_o = regs_q[raddr2_i];
        if (WB_BYPASS && we_i && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end else begin
            rdata1_o = regs_q[raddr1_i];
        end
        if (WB_BYPASS && we_i && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end else begin
            rdata2_o = regs_q[raddr2_i];
        end
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// Instruction decode stage: register read, IN-port operand select, load-use
// hazard detection and the ID/EX pipeline register with stall/flush.
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RADDR_W    = DEF_RADDR_W,
    parameter int SIG_W      = DEF_SIG_W,
    parameter int INPORT_BIT = DEF_INPORT_BIT,
    parameter int MEMRD_BIT  = DEF_MEMRD_BIT,
    parameter bit WB_BYPASS  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [SIG_W-1:0]   sig_in,
    input  logic [RADDR_W-1:0] rsrc1,
    input  logic [RADDR_W-1:0] rsrc2,
    input  logic [RADDR_W-1:0] rdst,
    input  logic [DATA_W-1:0]  in_port,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               flush,
    input  logic               ex_stall,
    output logic               stall_out,
    output logic               ex_valid,
    output logic [SIG_W-1:0]   ex_sig,
    output logic [DATA_W-1:0]  ex_opa,
    output logic [DATA_W-1:0]  ex_opb,
    output logic [RADDR_W-1:0] ex_rsrc1,
    output logic [RADDR_W-1:0] ex_rsrc2,
    output logic [RADDR_W-1:0] ex_rdst
);

    typedef struct packed {
        logic               valid;
        logic [SIG_W-1:0]   sig;
        logic [DATA_W-1:0]  opa;
        logic [DATA_W-1:0]  opb;
        logic [RADDR_W-1:0] rsrc1;
        logic [RADDR_W-1:0] rsrc2;
        logic [RADDR_W-1:0] rdst;
    } idex_t;

    idex_t             idex_q;
    idex_t             idex_d;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;
    logic [DATA_W-1:0] opa_s;
    logic              hz_s;

    reg_file_param #(
        .DATA_W    (DATA_W),
        .RADDR_W   (RADDR_W),
        .WB_BYPASS (WB_BYPASS)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wb_we),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data),
        .raddr1_i (rsrc1),
        .raddr2_i (rsrc2),
        .rdata1_o (rd1_s),
        .rdata2_o (rd2_s)
    );

    // Operand A select and load-use hazard; rsrc1 counts even when IN port is used.
    always_comb begin
        if (sig_in[INPORT_BIT]) begin
            opa_s = in_port;
        end else begin
            opa_s = rd1_s;
        end
        hz_s      = idex_q.valid & idex_q.sig[MEMRD_BIT] & id_valid &
                    ((idex_q.rdst == rsrc1) | (idex_q.rdst == rsrc2));
        stall_out = hz_s | ex_stall;
    end

    // ID/EX next state: EX stall holds, flush or hazard inserts a bubble.
    always_comb begin
        idex_d = idex_q;
        if (ex_stall) begin
            idex_d = idex_q;
        end else if (flush || hz_s) begin
            idex_d = '0;
        end else begin
            idex_d.valid = id_valid;
            idex_d.sig   = id_valid ? sig_in : '0;
            idex_d.opa   = opa_s;
            idex_d.opb   = rd2_s;
            idex_d.rsrc1 = rsrc1;
            idex_d.rsrc2 = rsrc2;
            idex_d.rdst  = rdst;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign ex_valid = idex_q.valid;
    assign ex_sig   = idex_q.sig;
    assign ex_opa   = idex_q.opa;
    assign ex_opb   = idex_q.opb;
    assign ex_rsrc1 = idex_q.rsrc1;
    assign ex_rsrc2 = idex_q.rsrc2;
    assign ex_rdst  = idex_q.rdst;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Randomized and directed bench for decode_stage_pipe against a register-array
// and pipeline-record reference model.
module tb_decode_stage_pipe;
    import decode_pkg::*;

    localparam bit WB_BYPASS = 1'b1;
    localparam int MEMRD = DEF_MEMRD_BIT;
    localparam int INPRT = DEF_INPORT_BIT;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   id_valid = 1'b0;
    logic [DEF_SIG_W-1:0]   sig_in = '0;
    logic [DEF_RADDR_W-1:0] rsrc1 = '0, rsrc2 = '0, rdst = '0, wb_addr = '0;
    logic [DEF_DATA_W-1:0]  in_port = '0, wb_data = '0;
    logic                   wb_we = 1'b0, flush = 1'b0, ex_stall = 1'b0;
    logic                   stall_out, ex_valid;
    logic [DEF_SIG_W-1:0]   ex_sig;
    logic [DEF_DATA_W-1:0]  ex_opa, ex_opb;
    logic [DEF_RADDR_W-1:0] ex_rsrc1, ex_rsrc2, ex_rdst;

    int checks = 0;
    int errors = 0;

    logic [DEF_DATA_W-1:0] mem [8];
    idex_payload_t         m_ex;

    decode_stage_pipe #(.WB_BYPASS(WB_BYPASS)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .sig_in(sig_in),
        .rsrc1(rsrc1), .rsrc2(rsrc2), .rdst(rdst), .in_port(in_port),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .ex_stall(ex_stall), .stall_out(stall_out),
        .ex_valid(ex_valid), .ex_sig(ex_sig), .ex_opa(ex_opa), .ex_opb(ex_opb),
        .ex_rsrc1(ex_rsrc1), .ex_rsrc2(ex_rsrc2), .ex_rdst(ex_rdst)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_ex(input string tag);
        check_eq({tag, ".valid"}, 32'(ex_valid), 32'(m_ex.valid));
        check_eq({tag, ".sig"},   32'(ex_sig),   32'(m_ex.sig));
        check_eq({tag, ".opa"},   32'(ex_opa),   32'(m_ex.opa));
        check_eq({tag, ".opb"},   32'(ex_opb),   32'(m_ex.opb));
        check_eq({tag, ".rs1"},   32'(ex_rsrc1), 32'(m_ex.rsrc1));
        check_eq({tag, ".rs2"},   32'(ex_rsrc2), 32'(m_ex.rsrc2));
        check_eq({tag, ".rd"},    32'(ex_rdst),  32'(m_ex.rdst));
    endtask

    function automatic logic [DEF_DATA_W-1:0] model_read(input logic [DEF_RADDR_W-1:0] a);
        if (WB_BYPASS && wb_we && wb_addr == a) return wb_data;
        return mem[a];
    endfunction

    // One clock: checks stall_out before the edge, ID/EX contents just after it.
    task automatic cycle(input string tag);
        bit hz;
        idex_payload_t nxt;
        #1;
        hz = m_ex.valid && m_ex.sig[MEMRD] && id_valid &&
             (m_ex.rdst == rsrc1 || m_ex.rdst == rsrc2);
        check_eq({tag, ".stall_out"}, 32'(stall_out), 32'(hz || ex_stall));
        nxt = m_ex;
        if (ex_stall) nxt = m_ex;
        else if (flush || hz) nxt = '0;
        else begin
            nxt.valid = id_valid;
            nxt.sig   = id_valid ? sig_in : '0;
            nxt.opa   = sig_in[INPRT] ? in_port : model_read(rsrc1);
            nxt.opb   = model_read(rsrc2);
            nxt.rsrc1 = rsrc1;
            nxt.rsrc2 = rsrc2;
            nxt.rdst  = rdst;
        end
        @(posedge clk);
        if (wb_we) mem[wb_addr] = wb_data;
        m_ex = nxt;
        #1;
        check_ex(tag);
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; sig_in = '0; wb_we = 1'b0; flush = 1'b0; ex_stall = 1'b0;
        rsrc1 = '0; rsrc2 = '0; rdst = '0; in_port = '0; wb_addr = '0; wb_data = '0;
    endtask

    // Asynchronous reset pulse away from the clock edge.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        m_ex = '0;
        check_ex("rst_async");
        check_eq("rst_stall_out", 32'(stall_out), 32'(ex_stall));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [DEF_SIG_W-1:0] held_sig;

    initial begin
        idle_inputs();
        m_ex = '0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_ex("reset");

        // 1. R3 written, then cleared by reset
        wb_we = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234;
        cycle("wr_r3");
        idle_inputs();
        pulse_reset();
        id_valid = 1'b1; rsrc1 = 3'd3; rsrc2 = 3'd3;
        cycle("rd_r3");
        check_eq("r3_after_reset", 32'(ex_opa), 32'h0000);

        // 2. same-cycle WB write and read
        idle_inputs();
        wb_we = 1'b1; wb_addr = 3'd5; wb_data = 16'h1111;
        cycle("wr_r5");
        wb_data = 16'hBEEF; id_valid = 1'b1; rsrc1 = 3'd5;
        cycle("bypass");
        check_eq("bypass_opa", 32'(ex_opa), WB_BYPASS ? 32'hBEEF : 32'h1111);

        // 3. IN port selects operand A
        idle_inputs();
        wb_we = 1'b1; wb_addr = 3'd1; wb_data = 16'h7777;
        cycle("wr_r1");
        idle_inputs();
        id_valid = 1'b1; sig_in[INPRT] = 1'b1; in_port = 16'h00A5; rsrc1 = 3'd1; rsrc2 = 3'd1;
        cycle("inport");
        check_eq("inport_opa", 32'(ex_opa), 32'h00A5);
        check_eq("inport_opb", 32'(ex_opb), 32'h7777);

        // 4. load-use: one bubble, then issue
        idle_inputs();
        id_valid = 1'b1; sig_in[MEMRD] = 1'b1; rdst = 3'd2; rsrc1 = 3'd6; rsrc2 = 3'd7;
        cycle("load");
        sig_in = 23'h000041; rsrc1 = 3'd4; rsrc2 = 3'd2; rdst = 3'd3;
        #1 check_eq("lu_stall", 32'(stall_out), 32'h1);
        cycle("lu_bubble");
        check_eq("lu_bubble_valid", 32'(ex_valid), 32'h0);
        cycle("lu_issue");
        check_eq("lu_issue_valid", 32'(ex_valid), 32'h1);
        check_eq("lu_issue_sig", 32'(ex_sig), 32'h000041);

        // 5. flush, and flush under EX stall
        sig_in = 23'h000123; rsrc2 = 3'd0;
        cycle("pre_flush");
        held_sig = ex_sig;
        flush = 1'b1; ex_stall = 1'b1;
        cycle("flush_stall");
        check_eq("flush_stall_sig", 32'(ex_sig), 32'(held_sig));
        ex_stall = 1'b0;
        cycle("flush");
        check_eq("flush_valid", 32'(ex_valid), 32'h0);
        flush = 1'b0;

        // 6. three stalled cycles, then resume
        cycle("pre_stall");
        held_sig = ex_sig;
        ex_stall = 1'b1; sig_in = 23'h000777;
        for (int i = 0; i < 3; i++) cycle("hold");
        check_eq("hold_sig", 32'(ex_sig), 32'(held_sig));
        ex_stall = 1'b0;
        cycle("resume");
        check_eq("resume_sig", 32'(ex_sig), 32'h000777);

        // reset in the middle of a stall with a load in ID/EX
        sig_in = '0; sig_in[MEMRD] = 1'b1; rdst = 3'd4;
        cycle("load2");
        ex_stall = 1'b1;
        pulse_reset();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            id_valid = ($urandom_range(0, 9) != 0);
            sig_in   = DEF_SIG_W'($urandom);
            rsrc1    = DEF_RADDR_W'($urandom);
            rsrc2    = DEF_RADDR_W'($urandom);
            rdst     = DEF_RADDR_W'($urandom);
            in_port  = DEF_DATA_W'($urandom);
            wb_we    = $urandom_range(0, 1) == 1;
            wb_addr  = DEF_RADDR_W'($urandom);
            wb_data  = DEF_DATA_W'($urandom);
            flush    = ($urandom_range(0, 9) == 0);
            ex_stall = ($urandom_range(0, 6) == 0);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
